// File: rtl/pool_or_spike_gate.sv
// pool_or_spike_gate
//   Spiking 2x2 OR-pooling stage. Each Conv1 AER event (ch,row,col on a
//   24x24 map) is folded onto its 12x12 pooled window; only the first spike
//   per window per timestep is forwarded as a 12-bit pooled AER event.
//   A one-bit-per-window "fired" bitmap suppresses repeats and is swept to
//   zero after reset and at every timestep boundary.
//
// Ports
//   work_clk             in   clock, rising edge
//   rst_n                in   asynchronous active-low reset
//   Conv1_AER_data_i     in   {ch[13:10], row[9:5], col[4:0]}
//   Conv1_spike_valid    in   event present, held stable until accepted
//   Conv1_spike_ready    out  event accepted on a cycle with valid & ready
//   timestep_end         in   single-cycle pulse ending the timestep
//   Pool_AER_data_o      out  {ch[11:8], prow[7:4], pcol[3:0]}, holds last value
//   Pool_spike_emit_flag out  one-cycle strobe, data valid while high
//   clear_busy           out  bitmap sweep in progress
//   drop_cnt             out  saturating count of out-of-range events
//   o_dbg_state          out  FSM state (0 CLEAR, 1 IDLE, 2 LOOKUP, 3 UPDATE)
//
// Handshake: an event transfers on a rising edge where Conv1_spike_valid and
// Conv1_spike_ready are both high; upstream keeps valid and data stable until
// then. Ready is low whenever a clear is pending, including the cycle that
// timestep_end is high, so a same-cycle clear always wins over an event.

module pool_or_spike_gate #(
  parameter int CH       = 16,
  parameter int IN_DIM   = 24,
  parameter int POOL_DIM = 12
) (
  input  logic        work_clk,
  input  logic        rst_n,
  input  logic [13:0] Conv1_AER_data_i,
  input  logic        Conv1_spike_valid,
  output logic        Conv1_spike_ready,
  input  logic        timestep_end,
  output logic [11:0] Pool_AER_data_o,
  output logic        Pool_spike_emit_flag,
  output logic        clear_busy,
  output logic [15:0] drop_cnt,
  output logic [1:0]  o_dbg_state
);

  localparam int          DEPTH     = CH * POOL_DIM * POOL_DIM;
  localparam logic [11:0] LAST_ADDR = 12'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_LOOKUP = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_clr_addr;
  logic        r_clr_pend;
  logic [11:0] r_idx;
  logic [11:0] r_pool_ev;
  logic        r_rd_bit;
  logic        r_emit;
  logic [11:0] r_out;
  logic [15:0] r_drop;
  logic        r_bitmap [0:DEPTH-1];

  logic [3:0]  w_ch;
  logic [4:0]  w_row;
  logic [4:0]  w_col;
  logic        w_ch_oor;
  logic        w_oor;
  logic        w_clear_pending;
  logic        w_accept;
  logic [11:0] w_idx;

  assign w_ch  = Conv1_AER_data_i[13:10];
  assign w_row = Conv1_AER_data_i[9:5];
  assign w_col = Conv1_AER_data_i[4:0];

  // With 16 channels every 4-bit channel code is legal.
  if (CH < 16) begin : g_ch_check
    assign w_ch_oor = (w_ch >= 4'(CH));
  end else begin : g_ch_full
    assign w_ch_oor = 1'b0;
  end

  assign w_oor = w_ch_oor || (w_row >= 5'(IN_DIM)) || (w_col >= 5'(IN_DIM));

  // A pulse arriving this very cycle counts as pending so the event waits.
  assign w_clear_pending = r_clr_pend | timestep_end;
  assign w_accept        = Conv1_spike_valid & Conv1_spike_ready;

  assign w_idx = 12'(w_ch) * 12'(POOL_DIM * POOL_DIM)
               + 12'(w_row[4:1]) * 12'(POOL_DIM)
               + 12'(w_col[4:1]);

  // State register
  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CLEAR;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR:  if (r_clr_addr == LAST_ADDR) w_next = S_IDLE;
      S_IDLE: begin
        if (w_clear_pending)                    w_next = S_CLEAR;
        else if (Conv1_spike_valid && !w_oor)   w_next = S_LOOKUP;
      end
      S_LOOKUP: w_next = S_UPDATE;
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_CLEAR;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    Conv1_spike_ready = (r_state == S_IDLE) && !w_clear_pending;
    clear_busy        = (r_state == S_CLEAR);
    o_dbg_state       = r_state;
  end

  assign Pool_AER_data_o      = r_out;
  assign Pool_spike_emit_flag = r_emit;
  assign drop_cnt             = r_drop;

  // Control and output registers
  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_addr <= '0;
      r_clr_pend <= 1'b0;
      r_idx      <= '0;
      r_pool_ev  <= '0;
      r_emit     <= 1'b0;
      r_out      <= '0;
      r_drop     <= '0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_clr_addr <= (r_clr_addr == LAST_ADDR) ? 12'd0 : r_clr_addr + 12'd1;
      end

      // A pulse during the sweep is absorbed: the sweep already covers it.
      if (r_state == S_IDLE && w_clear_pending) r_clr_pend <= 1'b0;
      else if (timestep_end && r_state != S_CLEAR) r_clr_pend <= 1'b1;

      if (w_accept && !w_oor) begin
        r_idx     <= w_idx;
        r_pool_ev <= {w_ch, w_row[4:1], w_col[4:1]};
      end

      if (w_accept && w_oor && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;

      r_emit <= (r_state == S_UPDATE) && !r_rd_bit;
      if (r_state == S_UPDATE && !r_rd_bit) r_out <= r_pool_ev;
    end
  end

  // Fired bitmap: one synchronous read port, one write port. Contents are
  // not reset; the sweep after reset establishes them.
  always_ff @(posedge work_clk) begin
    if (r_state == S_CLEAR)                    r_bitmap[r_clr_addr] <= 1'b0;
    else if (r_state == S_UPDATE && !r_rd_bit) r_bitmap[r_idx]      <= 1'b1;
    if (r_state == S_LOOKUP)                   r_rd_bit <= r_bitmap[r_idx];
  end

endmodule

// File: doc/pool_or_spike_gate.md
# pool_or_spike_gate

Spiking 2×2 OR-pooling stage between the Conv1 spike output and the Pool→Conv2 event FIFO. Takes Conv1 AER events (channel, row, col on a 24×24 map), maps each to its pooled 12×12 window, and forwards only the first spike per window per timestep as a 12-bit pooled AER event with a one-cycle emit flag. A per-window "fired" bitmap suppresses repeats and is swept clear at every timestep boundary and after reset.

## Interface
- CH, 16: number of Conv1 output channels; channel field is 4 bits.
- IN_DIM, 24: Conv1 map side; row and col fields are 5 bits.
- POOL_DIM, 12: pooled map side, IN_DIM/2.
- work_clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- Conv1_AER_data_i  in  14  {ch[13:10], row[9:5], col[4:0]}.
- Conv1_spike_valid  in  1  event present; held with data stable until accepted.
- Conv1_spike_ready  out  1  block accepts an event this cycle.
- timestep_end  in  1  single-cycle pulse; ends the current timestep.
- Pool_AER_data_o  out  12  {ch[11:8], prow[7:4], pcol[3:0]}.
- Pool_spike_emit_flag  out  1  one-cycle strobe; Pool_AER_data_o valid while high.
- clear_busy  out  1  bitmap sweep in progress.
- drop_cnt  out  16  count of out-of-range events dropped; saturates at 0xFFFF.

## Operation
- Bitmap: CH·POOL_DIM² = 2304 one-bit entries, synchronous read/write; index = ch·144 + prow·12 + pcol (12 bits), prow = row>>1, pcol = col>>1.
- FSM states: S_CLEAR, S_IDLE, S_LOOKUP, S_UPDATE.
- S_CLEAR: write 0 at clr_addr, clr_addr++ each cycle; after writing 2303 → S_IDLE, clr_addr ← 0. clear_busy = 1 only here.
- S_IDLE: if clear pending → S_CLEAR (priority over events). Else if Conv1_spike_valid: latch event; if ch ≥ CH or row ≥ IN_DIM or col ≥ IN_DIM → drop (drop_cnt++), stay S_IDLE; else compute index → S_LOOKUP.
- S_LOOKUP: issue bitmap read → S_UPDATE.
- S_UPDATE: if read bit = 0: write 1 at index, register Pool_AER_data_o and pulse Pool_spike_emit_flag; if 1: no output. → S_IDLE.
- Conv1_spike_ready = (state == S_IDLE) && !clear_pending, combinational from registered state.
- Clear pending: set by timestep_end in any state; cleared on entering S_CLEAR. timestep_end during S_CLEAR is ignored (sweep already in progress).
- Pool_AER_data_o holds last emitted value between strobes.

## Timing
- Reset values: state S_CLEAR, clr_addr 0, Pool_spike_emit_flag 0, Pool_AER_data_o 0, drop_cnt 0, clear pending 0, clear_busy 1, Conv1_spike_ready 0.
- After rst_n release: 2304 cycles in S_CLEAR, then ready high.
- Event accepted at edge k (valid & ready): S_LOOKUP after k, S_UPDATE after k+1, emit flag high for the single cycle after edge k+2; ready high again after edge k+2. Throughput: one event per 3 cycles.
- Dropped event: consumed at edge k, ready stays high, next event acceptable at edge k+1.
- timestep_end during S_LOOKUP/S_UPDATE: in-flight event completes against the old bitmap (may emit), then S_CLEAR from S_IDLE; ready low throughout.
- timestep_end and valid at same S_IDLE edge: clear wins; event not accepted, held by upstream.
- Emit strobe never back-to-back; downstream FIFO sees ≥2 idle cycles between writes.
- rst_n assertion mid-operation: immediate return to reset values, in-flight event lost, full sweep restarts.

## Test plan
- Reset → clear_busy high exactly 2304 cycles, ready 0 throughout, no emit; then ready 1.
- Event {ch=3,row=7,col=10} → emit 3 edges later, Pool_AER_data_o = {3,3,5} = 12'h335, flag high one cycle.
- Then {ch=3,row=6,col=11} (same window) → no emit; {ch=3,row=8,col=10} → emit 12'h345.
- timestep_end pulse, wait 2304 cycles, resend {3,7,10} → emits 12'h335 again.
- Events {ch=2,row=24,col=0} and {ch=2,row=0,col=31} → no emit, drop_cnt = 2, each consumed in one cycle.
- timestep_end asserted while event {0,0,0} in S_LOOKUP → event emits 12'h000, then clear_busy rises next cycle; rst_n pulsed mid-sweep → sweep restarts at address 0.
